// File: rtl/processor_status_register_if.sv
// Bus bundle between the ALU/decoder side and the 6502 status register (P).
interface processor_status_register_if;
    logic [7:0] i_db;
    logic       i_acr;
    logic       i_avr;
    logic       i_ir5;
    logic       i_db0_c;
    logic       i_ir5_c;
    logic       i_acr_c;
    logic       i_db1_z;
    logic       i_dbz_z;
    logic       i_db2_i;
    logic       i_ir5_i;
    logic       i_1_i;
    logic       i_db3_d;
    logic       i_ir5_d;
    logic       i_db6_v;
    logic       i_avr_v;
    logic       i_0_v;
    logic       i_db7_n;
    logic       i_p_db;
    logic       i_brk;
    logic [7:0] o_p;
    logic [7:0] o_db;
    logic       o_irq_mask;

    modport master (
        output i_db, i_acr, i_avr, i_ir5,
        output i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
        output i_db2_i, i_ir5_i, i_1_i, i_db3_d, i_ir5_d,
        output i_db6_v, i_avr_v, i_0_v, i_db7_n, i_p_db, i_brk,
        input  o_p, o_db, o_irq_mask
    );

    modport slave (
        input  i_db, i_acr, i_avr, i_ir5,
        input  i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
        input  i_db2_i, i_ir5_i, i_1_i, i_db3_d, i_ir5_d,
        input  i_db6_v, i_avr_v, i_0_v, i_db7_n, i_p_db, i_brk,
        output o_p, o_db, o_irq_mask
    );
endinterface

// File: rtl/processor_status_register.sv
// 6502 processor status register (P), updated on the falling edge of i_clk.
// Optional macro STATUS_IRQ_DELAY_EN: IRQ mask lags I by one cycle via a shadow register.
module processor_status_register #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    processor_status_register_if.slave    bus
);

    logic c_q, z_q, i_q, d_q, v_q, n_q;
    logic c_d, z_d, i_d, d_d, v_d, n_d;

    // Per-flag select priority; a flag holds when none of its selects is active.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        i_d = i_q;
        d_d = d_q;
        v_d = v_q;
        n_d = n_q;

        if (bus.i_db0_c)      c_d = bus.i_db[0];
        else if (bus.i_ir5_c) c_d = bus.i_ir5;
        else if (bus.i_acr_c) c_d = bus.i_acr;

        if (bus.i_db1_z)      z_d = bus.i_db[1];
        else if (bus.i_dbz_z) z_d = (bus.i_db == 8'h00);

        if (bus.i_1_i)        i_d = 1'b1;
        else if (bus.i_db2_i) i_d = bus.i_db[2];
        else if (bus.i_ir5_i) i_d = bus.i_ir5;

        if (bus.i_db3_d)      d_d = bus.i_db[3];
        else if (bus.i_ir5_d) d_d = bus.i_ir5;

        if (bus.i_db6_v)      v_d = bus.i_db[6];
        else if (bus.i_avr_v) v_d = bus.i_avr;
        else if (bus.i_0_v)   v_d = 1'b0;

        if (bus.i_db7_n)      n_d = bus.i_db[7];
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            c_q <= RESET_P[0];
            z_q <= RESET_P[1];
            i_q <= RESET_P[2];
            d_q <= RESET_P[3];
            v_q <= RESET_P[6];
            n_q <= RESET_P[7];
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            i_q <= i_d;
            d_q <= d_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    // Bits 5 and 4 are not storage: they always read back as 1.
    assign bus.o_p  = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign bus.o_db = bus.i_p_db ? {n_q, v_q, 1'b1, bus.i_brk, d_q, i_q, z_q, c_q} : 8'hFF;

`ifdef STATUS_IRQ_DELAY_EN
    logic irq_mask_q;

    // Shadow copy of I gives the one-instruction CLI/SEI/PLP latency.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) irq_mask_q <= 1'b1;
        else         irq_mask_q <= i_q;
    end

    assign bus.o_irq_mask = irq_mask_q;
`else
    assign bus.o_irq_mask = i_q;
`endif

endmodule

// File: tb/tb_processor_status_register.sv
// Directed, table-driven bench for the 6502 status register.
module tb_processor_status_register;

    logic i_clk;
    logic i_reset;

    processor_status_register_if bus ();

    processor_status_register #(.RESET_P(8'h34)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam int unsigned NSEL = 14;
    localparam logic [NSEL-1:0] DB0_C = 14'd1 << 0;
    localparam logic [NSEL-1:0] IR5_C = 14'd1 << 1;
    localparam logic [NSEL-1:0] ACR_C = 14'd1 << 2;
    localparam logic [NSEL-1:0] DB1_Z = 14'd1 << 3;
    localparam logic [NSEL-1:0] DBZ_Z = 14'd1 << 4;
    localparam logic [NSEL-1:0] DB2_I = 14'd1 << 5;
    localparam logic [NSEL-1:0] IR5_I = 14'd1 << 6;
    localparam logic [NSEL-1:0] ONE_I = 14'd1 << 7;
    localparam logic [NSEL-1:0] DB3_D = 14'd1 << 8;
    localparam logic [NSEL-1:0] IR5_D = 14'd1 << 9;
    localparam logic [NSEL-1:0] DB6_V = 14'd1 << 10;
    localparam logic [NSEL-1:0] AVR_V = 14'd1 << 11;
    localparam logic [NSEL-1:0] ZRO_V = 14'd1 << 12;
    localparam logic [NSEL-1:0] DB7_N = 14'd1 << 13;

    typedef struct {
        string           name;
        logic [7:0]      db;
        logic            acr;
        logic            avr;
        logic            ir5;
        logic [NSEL-1:0] sel;
        logic            p_db;
        logic            brk;
        logic [7:0]      exp_p;
        logic [7:0]      exp_db;
        logic            exp_mask;
        logic            exp_mask_dly;
        logic            chk_pre;
        logic [7:0]      exp_db_pre;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic [7:0] db, input logic acr, input logic avr,
                       input logic ir5, input logic [NSEL-1:0] sel, input logic p_db, input logic brk,
                       input logic [7:0] exp_p, input logic [7:0] exp_db, input logic exp_mask,
                       input logic exp_mask_dly, input logic chk_pre, input logic [7:0] exp_db_pre);
        vec_t v;
        v.name = name; v.db = db; v.acr = acr; v.avr = avr; v.ir5 = ir5; v.sel = sel;
        v.p_db = p_db; v.brk = brk; v.exp_p = exp_p; v.exp_db = exp_db;
        v.exp_mask = exp_mask; v.exp_mask_dly = exp_mask_dly;
        v.chk_pre = chk_pre; v.exp_db_pre = exp_db_pre;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] db, input logic acr, input logic avr, input logic ir5,
                         input logic [NSEL-1:0] sel, input logic p_db, input logic brk);
        bus.i_db    = db;
        bus.i_acr   = acr;
        bus.i_avr   = avr;
        bus.i_ir5   = ir5;
        bus.i_db0_c = sel[0];
        bus.i_ir5_c = sel[1];
        bus.i_acr_c = sel[2];
        bus.i_db1_z = sel[3];
        bus.i_dbz_z = sel[4];
        bus.i_db2_i = sel[5];
        bus.i_ir5_i = sel[6];
        bus.i_1_i   = sel[7];
        bus.i_db3_d = sel[8];
        bus.i_ir5_d = sel[9];
        bus.i_db6_v = sel[10];
        bus.i_avr_v = sel[11];
        bus.i_0_v   = sel[12];
        bus.i_db7_n = sel[13];
        bus.i_p_db  = p_db;
        bus.i_brk   = brk;
    endtask

    function automatic logic [7:0] pick_mask(input logic m, input logic m_dly);
`ifdef STATUS_IRQ_DELAY_EN
        pick_mask = {7'd0, m_dly};
`else
        pick_mask = {7'd0, m};
`endif
    endfunction

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Starting from P = 34, each row's expectation follows from the previous row.
        //   name          db     acr  avr  ir5  sel                           pdb  brk  exp_p  exp_db mask dly  pre  db_pre
        add("adc",        8'h80, 1'b1, 1'b1, 1'b0, ACR_C|AVR_V|DBZ_Z|DB7_N,     1'b0, 1'b0, 8'hF5, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("adc_hold",   8'h00, 1'b0, 1'b0, 1'b0, '0,                          1'b0, 1'b0, 8'hF5, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("plp",        8'hCF, 1'b0, 1'b0, 1'b0, DB0_C|DB1_Z|DB2_I|DB3_D|DB6_V|DB7_N, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("php",        8'h00, 1'b0, 1'b0, 1'b0, '0,                          1'b1, 1'b0, 8'hFF, 8'hEF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("php_off",    8'h00, 1'b0, 1'b0, 1'b0, '0,                          1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("c_pri_db0",  8'h00, 1'b1, 1'b0, 1'b0, DB0_C|IR5_C|ACR_C,           1'b0, 1'b0, 8'hFE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("c_pri_db1",  8'h01, 1'b1, 1'b0, 1'b0, DB0_C|IR5_C|ACR_C,           1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("c_pri_ir5",  8'h00, 1'b1, 1'b0, 1'b0, IR5_C|ACR_C,                 1'b0, 1'b0, 8'hFE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("cli",        8'h00, 1'b0, 1'b0, 1'b0, IR5_I,                       1'b0, 1'b0, 8'hFA, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
        add("cli_next",   8'h00, 1'b0, 1'b0, 1'b0, '0,                          1'b0, 1'b0, 8'hFA, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
        add("irq_entry",  8'h00, 1'b0, 1'b0, 1'b0, ONE_I|IR5_I|ZRO_V,           1'b1, 1'b1, 8'hBE, 8'hBE, 1'b1, 1'b0, 1'b1, 8'hFA);
        add("push_brk0",  8'h00, 1'b0, 1'b0, 1'b0, '0,                          1'b1, 1'b0, 8'hBE, 8'hAE, 1'b1, 1'b1, 1'b0, 8'h00);
        add("v_avr",      8'h00, 1'b0, 1'b1, 1'b0, AVR_V|ZRO_V,                 1'b0, 1'b0, 8'hFE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("v_db6",      8'h00, 1'b0, 1'b1, 1'b0, DB6_V|AVR_V|ZRO_V,           1'b0, 1'b0, 8'hBE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("i_db2_pri",  8'h00, 1'b0, 1'b0, 1'b1, DB2_I|IR5_I,                 1'b0, 1'b0, 8'hBA, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
        add("i_one_pri",  8'h00, 1'b0, 1'b0, 1'b0, ONE_I|DB2_I,                 1'b0, 1'b0, 8'hBE, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
        add("d_db3_pri",  8'h00, 1'b0, 1'b0, 1'b1, DB3_D|IR5_D,                 1'b0, 1'b0, 8'hB6, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("d_ir5",      8'h00, 1'b0, 1'b0, 1'b1, IR5_D,                       1'b0, 1'b0, 8'hBE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("z_db1_pri",  8'h00, 1'b0, 1'b0, 1'b0, DB1_Z|DBZ_Z,                 1'b0, 1'b0, 8'hBC, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("z_dbz_set",  8'h00, 1'b0, 1'b0, 1'b0, DBZ_Z,                       1'b0, 1'b0, 8'hBE, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("z_dbz_clr",  8'h01, 1'b0, 1'b0, 1'b0, DBZ_Z,                       1'b0, 1'b0, 8'hBC, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("n_db7",      8'h00, 1'b0, 1'b0, 1'b0, DB7_N,                       1'b0, 1'b0, 8'h3C, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        add("bits54_const", 8'h00, 1'b0, 1'b0, 1'b0, DB0_C|DB1_Z|DB2_I|DB3_D|DB6_V|DB7_N, 1'b1, 1'b0, 8'h30, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset asserted from time zero, checked between clock edges.
        i_reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        check("rst_p", bus.o_p, 8'h34);
        check("rst_mask", {7'd0, bus.o_irq_mask}, 8'h01);
        check("rst_db_idle", bus.o_db, 8'hFF);
        bus.i_p_db = 1'b1;
        #1;
        check("rst_db_push", bus.o_db, 8'h24);
        bus.i_p_db = 1'b0;

        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); #1;
            check("idle_after_rst", bus.o_p, 8'h34);
        end

        foreach (vecs[k]) begin
            @(posedge i_clk); #1;
            drive(vecs[k].db, vecs[k].acr, vecs[k].avr, vecs[k].ir5, vecs[k].sel, vecs[k].p_db, vecs[k].brk);
            if (vecs[k].chk_pre) begin
                #2;
                check({vecs[k].name, "_db_pre"}, bus.o_db, vecs[k].exp_db_pre);
            end
            @(negedge i_clk); #1;
            check({vecs[k].name, "_p"}, bus.o_p, vecs[k].exp_p);
            check({vecs[k].name, "_db"}, bus.o_db, vecs[k].exp_db);
            check({vecs[k].name, "_mask"}, {7'd0, bus.o_irq_mask},
                  pick_mask(vecs[k].exp_mask, vecs[k].exp_mask_dly));
        end

        // Reset mid-operation overrides pending updates, including across a falling edge.
        @(posedge i_clk); #1;
        drive(8'hFF, 1'b1, 1'b1, 1'b1, DB0_C|DB1_Z|DB2_I|DB3_D|DB6_V|DB7_N, 1'b0, 1'b0);
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_p", bus.o_p, 8'h34);
        check("midrst_mask", {7'd0, bus.o_irq_mask}, 8'h01);
        @(negedge i_clk); #1;
        check("midrst_hold_p", bus.o_p, 8'h34);

        // First update after release lands on the next falling edge.
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        drive(8'h80, 1'b0, 1'b0, 1'b0, DB7_N, 1'b0, 1'b0);
        #2;
        check("post_rst_pre_edge", bus.o_p, 8'h34);
        @(negedge i_clk); #1;
        check("post_rst_first_upd", bus.o_p, 8'hB4);
        check("post_rst_mask", {7'd0, bus.o_irq_mask}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
